// File: rtl/uart_pkt_pkg.sv
// Shared constants for the UART packet parser: sync byte, FSM encodings and
// the running-checksum helper.
package uart_pkt_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LEN     = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_CSUM    = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/uart_pkt_parser_if.sv
// Byte-stream input and held-packet read port of the UART packet parser.
interface uart_pkt_parser_if #(
  parameter int MAX_LEN = 16
);
  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [7:0]        rx_data;
  logic              rx_done;
  logic              pkt_valid;
  logic              pkt_ready;
  logic [LEN_W-1:0]  pkt_len;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;

  // pkt_valid holds (with pkt_len and buffer frozen) until a cycle with
  // pkt_ready high; pkt_valid drops on the following cycle.
  modport master (
    input  rx_data, rx_done, pkt_ready, rd_addr,
    output pkt_valid, pkt_len, rd_data
  );

  modport slave (
    output rx_data, rx_done, pkt_ready, rd_addr,
    input  pkt_valid, pkt_len, rd_data
  );

endinterface

// File: rtl/uart_pkt_buf.sv
// Payload store: register array, synchronous write, asynchronous read.
module uart_pkt_buf #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Addresses past DEPTH (non power-of-two sizes) read as zero.
  always_comb begin
    rdata_o = 8'h00;
    if (int'(raddr_i) < DEPTH) rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/uart_pkt_parser.sv
// Frames SYNC/LEN/payload/CSUM packets from a UART byte stream and holds good
// ones for the consumer. Optional statistics counters under UART_PKT_STATS_EN.
module uart_pkt_parser
  import uart_pkt_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD_RATE    = 9600,
  parameter int MAX_LEN      = 16,
  parameter int TIMEOUT_CLKS = (CLK_FREQ / BAUD_RATE) * 20
) (
  input  logic                clk,
  input  logic                rst,
  uart_pkt_parser_if.master   bus,
  output logic                busy,
  output logic                err_len,
  output logic                err_csum,
  output logic                err_timeout,
  output logic                err_overrun,
`ifdef UART_PKT_STATS_EN
  output logic [15:0]         good_cnt,
  output logic [15:0]         err_cnt,
`endif
  output logic [2:0]          dbg_state
);

  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);

  logic [2:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [7:0]       sum_q, sum_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic e_len_q, e_len_d, e_csum_q, e_csum_d, e_tmo_q, e_tmo_d, e_ovr_q, e_ovr_d;
  logic             active;
  logic [7:0]       buf_rdata;

  assign active = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    tmo_d   = '0;
    e_len_d = 1'b0;
    e_csum_d = 1'b0;
    e_tmo_d = 1'b0;
    e_ovr_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.rx_done && bus.rx_data == SYNC_BYTE) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (bus.rx_done) begin
          if (bus.rx_data != 8'h00 && int'(bus.rx_data) <= MAX_LEN) begin
            len_d   = bus.rx_data[LEN_W-1:0];
            sum_d   = bus.rx_data;
            idx_d   = '0;
            state_d = ST_PAYLOAD;
          end else begin
            e_len_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_PAYLOAD: begin
        if (bus.rx_done) begin
          sum_d = csum_add(sum_q, bus.rx_data);
          idx_d = idx_q + LEN_ONE;
          if (idx_d == len_q) state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (bus.rx_done) begin
          if (csum_add(sum_q, bus.rx_data) == 8'h00) begin
            state_d = ST_HOLD;
          end else begin
            e_csum_d = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        // A release cycle also treats the incoming byte as if already idle.
        if (bus.pkt_ready) begin
          state_d = (bus.rx_done && bus.rx_data == SYNC_BYTE) ? ST_LEN : ST_IDLE;
        end else if (bus.rx_done) begin
          e_ovr_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (active && !bus.rx_done) begin
      if (tmo_q == TMO_LAST) begin
        e_tmo_d = 1'b1;
        state_d = ST_IDLE;
      end else begin
        tmo_d = tmo_q + TMO_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      idx_q    <= '0;
      sum_q    <= '0;
      tmo_q    <= '0;
      e_len_q  <= 1'b0;
      e_csum_q <= 1'b0;
      e_tmo_q  <= 1'b0;
      e_ovr_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      tmo_q    <= tmo_d;
      e_len_q  <= e_len_d;
      e_csum_q <= e_csum_d;
      e_tmo_q  <= e_tmo_d;
      e_ovr_q  <= e_ovr_d;
    end
  end

  uart_pkt_buf #(.DEPTH(MAX_LEN), .ADDR_W(ADDR_W)) u_buf (
    .clk     (clk),
    .we_i    (bus.rx_done && state_q == ST_PAYLOAD),
    .waddr_i (idx_q[ADDR_W-1:0]),
    .wdata_i (bus.rx_data),
    .raddr_i (bus.rd_addr),
    .rdata_o (buf_rdata)
  );

  assign bus.pkt_valid = (state_q == ST_HOLD);
  assign bus.pkt_len   = len_q;
  assign bus.rd_data   = bus.pkt_valid ? buf_rdata : 8'h00;
  assign busy          = (state_q != ST_IDLE);
  assign err_len       = e_len_q;
  assign err_csum      = e_csum_q;
  assign err_timeout   = e_tmo_q;
  assign err_overrun   = e_ovr_q;
  assign dbg_state     = state_q;

`ifdef UART_PKT_STATS_EN
  logic [15:0] good_q, errc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_q <= '0;
      errc_q <= '0;
    end else begin
      if (state_d == ST_HOLD && state_q != ST_HOLD && good_q != 16'hFFFF)
        good_q <= good_q + 16'd1;
      if ((e_len_d || e_csum_d || e_tmo_d || e_ovr_d) && errc_q != 16'hFFFF)
        errc_q <= errc_q + 16'd1;
    end
  end

  assign good_cnt = good_q;
  assign err_cnt  = errc_q;
`endif

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Directed bench for uart_pkt_parser (MAX_LEN 16, short timeout).
module tb_uart_pkt_parser;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, err_len, err_csum, err_timeout, err_overrun;
  logic [2:0] dbg_state;
`ifdef UART_PKT_STATS_EN
  logic [15:0] good_cnt, err_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  uart_pkt_parser_if #(.MAX_LEN(MAX_LEN)) bus ();

  uart_pkt_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CLKS(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .err_len     (err_len),
    .err_csum    (err_csum),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun),
`ifdef UART_PKT_STATS_EN
    .good_cnt    (good_cnt),
    .err_cnt     (err_cnt),
`endif
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
  endtask

  task automatic release_pkt(input string tag);
    @(negedge clk);
    bus.pkt_ready = 1'b1;
    @(negedge clk);
    bus.pkt_ready = 1'b0;
    chk({tag, "_valid_drop"}, bus.pkt_valid, 0);
    chk({tag, "_busy_idle"}, busy, 0);
  endtask

  task automatic read_chk(input string tag, input int addr, input logic [7:0] exp);
    bus.rd_addr = addr[3:0];
    #1;
    chk(tag, bus.rd_data, exp);
  endtask

  initial begin
    int cnt;
    bus.rx_data   = 8'h00;
    bus.rx_done   = 1'b0;
    bus.pkt_ready = 1'b0;
    bus.rd_addr   = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.pkt_valid, 0);
    chk("rst_len", bus.pkt_len, 0);
    chk("rst_rdata", bus.rd_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_errs", {err_len, err_csum, err_timeout, err_overrun}, 0);
    chk("rst_state", dbg_state, 0);
    rst = 1'b0;

    // Good packet: 03 + 11 + 22 + 33 + 97 = 0x100
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    chk("good_not_yet_valid", bus.pkt_valid, 0);
    send_byte(8'h97);
    chk("good_valid", bus.pkt_valid, 1);
    chk("good_len", bus.pkt_len, 3);
    chk("good_no_err", {err_len, err_csum, err_timeout, err_overrun}, 0);
    read_chk("good_rd0", 0, 8'h11);
    read_chk("good_rd1", 1, 8'h22);
    read_chk("good_rd2", 2, 8'h33);
    release_pkt("good");

    // Bad checksum: 02 + 10 + 20 + 00 = 0x32
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h00);
    chk("csum_pulse", err_csum, 1);
    chk("csum_valid", bus.pkt_valid, 0);
    chk("csum_busy", busy, 0);
    @(negedge clk);
    chk("csum_pulse_once", err_csum, 0);
    // 01 + 7F + 80 = 0x100
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
    chk("csum2_valid", bus.pkt_valid, 1);
    read_chk("csum2_rd0", 0, 8'h7F);
    release_pkt("csum2");

    // Junk before sync, then illegal lengths 0 and MAX_LEN+1
    send_byte(8'h00);
    chk("junk0", {busy, err_len, err_csum, err_timeout, err_overrun}, 0);
    send_byte(8'hFF);
    chk("junk1", {busy, err_len, err_csum, err_timeout, err_overrun}, 0);
    send_byte(8'hA5); send_byte(8'h00);
    chk("len0_pulse", err_len, 1);
    chk("len0_busy", busy, 0);
    send_byte(8'hA5); send_byte(8'h11);
    chk("len17_pulse", err_len, 1);
    chk("len17_busy", busy, 0);
    @(negedge clk);
    chk("len_pulse_once", err_len, 0);

    // Overrun while holding: 01 + 42 + BD = 0x100
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h42); send_byte(8'hBD);
    chk("ovr_valid", bus.pkt_valid, 1);
    send_byte(8'h55);
    chk("ovr_pulse", err_overrun, 1);
    chk("ovr_keep_valid", bus.pkt_valid, 1);
    read_chk("ovr_rd0", 0, 8'h42);
    // Release and sync byte in the same cycle
    @(negedge clk);
    bus.pkt_ready = 1'b1;
    bus.rx_data   = 8'hA5;
    bus.rx_done   = 1'b1;
    @(negedge clk);
    bus.pkt_ready = 1'b0;
    bus.rx_done   = 1'b0;
    chk("rel_no_ovr", err_overrun, 0);
    chk("rel_busy", busy, 1);
    chk("rel_state_len", dbg_state, 1);
    chk("rel_valid", bus.pkt_valid, 0);

    // Timeout: sync already taken, now LEN=2 and one payload byte, then idle
    send_byte(8'h02); send_byte(8'h11);
    cnt = 0;
    for (int i = 0; i < TMO - 1; i++) begin
      @(negedge clk);
      if (err_timeout) cnt++;
    end
    chk("tmo_early", cnt, 0);
    chk("tmo_busy_before", busy, 1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (err_timeout) cnt++;
    end
    chk("tmo_once", cnt, 1);
    chk("tmo_busy", busy, 0);
    // 02 + 10 + 20 + CE = 0x100
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'hCE);
    chk("tmo_after_valid", bus.pkt_valid, 1);
    chk("tmo_after_len", bus.pkt_len, 2);
    read_chk("tmo_after_rd1", 1, 8'h20);
    release_pkt("tmo_after");

    // Reset mid-packet
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    chk("mid_busy", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_state", dbg_state, 0);
    chk("mid_rst_outs", {bus.pkt_valid, busy, err_len, err_csum, err_timeout, err_overrun}, 0);
    chk("mid_rst_len", bus.pkt_len, 0);
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h42); send_byte(8'hBD);
    chk("post_rst_valid", bus.pkt_valid, 1);
    read_chk("post_rst_rd0", 0, 8'h42);
`ifdef UART_PKT_STATS_EN
    chk("stats_good", good_cnt, 1);
    chk("stats_err", err_cnt, 0);
`endif
    release_pkt("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
